// File: rtl/regfile_mp_bypass.sv
// Multi-port integer register file with optional write-to-read bypass and a
// per-register pending scoreboard used by decode to stall on in-flight loads.
module regfile_mp_bypass #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*AW-1:0]     wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic                     sb_set_en,
    input  logic [AW-1:0]            sb_set_addr,
    output logic [AW:0]              pending_cnt
);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] pending;
    logic [NUM_REGS-1:0] pending_nxt;
    logic [NUM_WR-1:0]   wr_ok;

    // An address is usable when it exists and is not the hardwired zero register.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (int'(a) < NUM_REGS) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    function automatic logic [AW:0] popcount(input logic [NUM_REGS-1:0] v);
        logic [AW:0] cnt;
        cnt = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            cnt += {{AW{1'b0}}, v[i]};
        end
        return cnt;
    endfunction

    for (genvar w = 0; w < NUM_WR; w++) begin : g_wr_ok
        assign wr_ok[w] = wr_en[w] && addr_ok(wr_addr[w*AW +: AW]);
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [AW-1:0]     ra;
        logic              hit;
        logic              busy;
        logic [DATA_W-1:0] fwd;
        logic [DATA_W-1:0] val;

        assign ra = rd_addr[p*AW +: AW];

        always_comb begin
            hit  = 1'b0;
            fwd  = '0;
            val  = '0;
            busy = 1'b0;
            // Ascending scan so the highest matching write port is the one forwarded.
            if (BYPASS != 0) begin
                for (int w = 0; w < NUM_WR; w++) begin
                    if (wr_ok[w] && (wr_addr[w*AW +: AW] == ra)) begin
                        hit = 1'b1;
                        fwd = wr_data[w*DATA_W +: DATA_W];
                    end
                end
            end
            if (addr_ok(ra)) begin
                val  = hit ? fwd : regs[ra];
                busy = pending[ra] & ~hit;
            end
        end

        assign rd_data[p*DATA_W +: DATA_W] = rst_n ? val : '0;
        assign rd_busy[p]                  = rst_n & busy;
    end

    // Writes retire older ops (clear); a same-cycle set is newer and wins.
    always_comb begin
        pending_nxt = pending;
        for (int w = 0; w < NUM_WR; w++) begin
            if (wr_ok[w]) begin
                pending_nxt[wr_addr[w*AW +: AW]] = 1'b0;
            end
        end
        if (sb_set_en && addr_ok(sb_set_addr)) begin
            pending_nxt[sb_set_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (wr_ok[w]) begin
                    regs[wr_addr[w*AW +: AW]] <= wr_data[w*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending     <= '0;
            pending_cnt <= '0;
        end else begin
            pending     <= pending_nxt;
            pending_cnt <= popcount(pending_nxt);
        end
    end

endmodule

// File: tb/tb_regfile_mp_bypass.sv
// Bench for regfile_mp_bypass: a 24-entry 4R/2W bypassing instance plus a
// default-size instance with bypass disabled.
module tb_regfile_mp_bypass;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [4*AW-1:0]  rd_addr;
    logic [4*32-1:0]  rd_data;
    logic [3:0]       rd_busy;
    logic [1:0]       wr_en;
    logic [2*AW-1:0]  wr_addr;
    logic [2*32-1:0]  wr_data;
    logic             sb_set_en;
    logic [AW-1:0]    sb_set_addr;
    logic [AW:0]      pending_cnt;

    logic [2*AW-1:0]  nb_rd_addr;
    logic [2*32-1:0]  nb_rd_data;
    logic [1:0]       nb_rd_busy;
    logic [1:0]       nb_wr_en;
    logic [2*AW-1:0]  nb_wr_addr;
    logic [2*32-1:0]  nb_wr_data;
    logic             nb_sb_set_en;
    logic [AW-1:0]    nb_sb_set_addr;
    logic [AW:0]      nb_pending_cnt;

    regfile_mp_bypass #(.DATA_W(32), .NUM_REGS(24), .NUM_RD(4), .NUM_WR(2),
                        .BYPASS(1), .ZERO_REG(1)) dut (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr), .pending_cnt(pending_cnt));

    regfile_mp_bypass #(.DATA_W(32), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(2),
                        .BYPASS(0), .ZERO_REG(1)) dut_nb (
        .clk(clk), .rst_n(rst_n), .rd_addr(nb_rd_addr), .rd_data(nb_rd_data),
        .rd_busy(nb_rd_busy), .wr_en(nb_wr_en), .wr_addr(nb_wr_addr), .wr_data(nb_wr_data),
        .sb_set_en(nb_sb_set_en), .sb_set_addr(nb_sb_set_addr), .pending_cnt(nb_pending_cnt));

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
        sb_set_en = 1'b0; sb_set_addr = '0;
        nb_rd_addr = '0; nb_wr_en = '0; nb_wr_addr = '0; nb_wr_data = '0;
        nb_sb_set_en = 1'b0; nb_sb_set_addr = '0;
    endtask

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        sb;
        logic [4:0]  sa;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  busy;
        logic [5:0]  cnt;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
                                input logic [4:0] wa1, input logic [31:0] wd1,
                                input logic sb, input logic [4:0] sa,
                                input logic [4:0] ra0, input logic [4:0] ra1,
                                input logic [31:0] d0, input logic [31:0] d1,
                                input logic [1:0] busy, input logic [5:0] cnt);
        vec_t v;
        v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
        v.sb = sb; v.sa = sa; v.ra0 = ra0; v.ra1 = ra1;
        v.d0 = d0; v.d1 = d1; v.busy = busy; v.cnt = cnt;
        return v;
    endfunction

    // Reference model for the random phase (24 regs, zero register, bypass on).
    logic [31:0] mregs [24];
    logic [23:0] mpend;

    function automatic logic m_ok(input int a);
        return (a > 0) && (a < 24);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vt[15];
        idle();

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        chk("reset rd_data", {32'h0, rd_data[63:32] | rd_data[31:0]}, 64'h0);
        chk("reset rd_busy", {60'h0, rd_busy}, 64'h0);
        chk("reset pending_cnt", {58'h0, pending_cnt}, 64'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Asynchronous reset mid-operation
        @(negedge clk);
        wr_en = 2'b01; wr_addr[0 +: AW] = 5'd5; wr_data[0 +: 32] = 32'hDEADBEEF;
        sb_set_en = 1'b1; sb_set_addr = 5'd7;
        @(negedge clk);
        idle();
        rd_addr[0 +: AW] = 5'd5; rd_addr[AW +: AW] = 5'd7;
        #1;
        chk("pre-reset r5", {32'h0, rd_data[31:0]}, 64'hDEADBEEF);
        chk("pre-reset busy r7", {63'h0, rd_busy[1]}, 64'h1);
        chk("pre-reset cnt", {58'h0, pending_cnt}, 64'h1);
        #1;
        wr_en = 2'b01; wr_addr[0 +: AW] = 5'd5; wr_data[0 +: 32] = 32'h1111;
        rst_n = 1'b0;
        #1;
        chk("async reset r5", {32'h0, rd_data[31:0]}, 64'h0);
        chk("async reset busy", {60'h0, rd_busy}, 64'h0);
        chk("async reset cnt", {58'h0, pending_cnt}, 64'h0);
        #1;
        wr_en = 2'b00;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("post-reset r5", {32'h0, rd_data[31:0]}, 64'h0);
        chk("post-reset cnt", {58'h0, pending_cnt}, 64'h0);

        // Directed vector table: checks are for the combinational outputs in that cycle
        //             we     wa0    wd0        wa1    wd1     sb    sa     ra0    ra1    d0         d1         busy   cnt
        vt[0]  = mk(2'b11, 5'd3,  32'hAAAA, 5'd3,  32'h5555, 1'b0, 5'd0,  5'd3,  5'd0,  32'h5555, 32'h0,     2'b00, 6'd0);
        vt[1]  = mk(2'b01, 5'd0,  32'hFFFF, 5'd0,  32'h0,    1'b0, 5'd0,  5'd3,  5'd0,  32'h5555, 32'h0,     2'b00, 6'd0);
        vt[2]  = mk(2'b00, 5'd0,  32'h0,    5'd0,  32'h0,    1'b1, 5'd9,  5'd0,  5'd9,  32'h0,    32'h0,     2'b00, 6'd0);
        vt[3]  = mk(2'b00, 5'd0,  32'h0,    5'd0,  32'h0,    1'b0, 5'd0,  5'd3,  5'd9,  32'h5555, 32'h0,     2'b10, 6'd1);
        vt[4]  = mk(2'b10, 5'd0,  32'h0,    5'd9,  32'h1234, 1'b0, 5'd0,  5'd3,  5'd9,  32'h5555, 32'h1234,  2'b00, 6'd1);
        vt[5]  = mk(2'b00, 5'd0,  32'h0,    5'd0,  32'h0,    1'b0, 5'd0,  5'd9,  5'd3,  32'h1234, 32'h5555,  2'b00, 6'd0);
        vt[6]  = mk(2'b01, 5'd4,  32'hBEEF, 5'd0,  32'h0,    1'b1, 5'd4,  5'd4,  5'd9,  32'hBEEF, 32'h1234,  2'b00, 6'd0);
        vt[7]  = mk(2'b00, 5'd0,  32'h0,    5'd0,  32'h0,    1'b1, 5'd0,  5'd4,  5'd0,  32'hBEEF, 32'h0,     2'b01, 6'd1);
        vt[8]  = mk(2'b00, 5'd0,  32'h0,    5'd0,  32'h0,    1'b1, 5'd4,  5'd0,  5'd4,  32'h0,    32'hBEEF,  2'b10, 6'd1);
        vt[9]  = mk(2'b00, 5'd0,  32'h0,    5'd0,  32'h0,    1'b1, 5'd23, 5'd4,  5'd23, 32'hBEEF, 32'h0,     2'b01, 6'd1);
        vt[10] = mk(2'b11, 5'd23, 32'h77,   5'd24, 32'h99,   1'b0, 5'd0,  5'd23, 5'd24, 32'h77,   32'h0,     2'b00, 6'd2);
        vt[11] = mk(2'b00, 5'd0,  32'h0,    5'd0,  32'h0,    1'b0, 5'd0,  5'd23, 5'd24, 32'h77,   32'h0,     2'b00, 6'd1);
        vt[12] = mk(2'b11, 5'd4,  32'h1,    5'd4,  32'h2,    1'b0, 5'd0,  5'd4,  5'd3,  32'h2,    32'h5555,  2'b00, 6'd1);
        vt[13] = mk(2'b00, 5'd0,  32'h0,    5'd0,  32'h0,    1'b1, 5'd30, 5'd4,  5'd23, 32'h2,    32'h77,    2'b00, 6'd0);
        vt[14] = mk(2'b00, 5'd0,  32'h0,    5'd0,  32'h0,    1'b0, 5'd0,  5'd30, 5'd4,  32'h0,    32'h2,     2'b00, 6'd0);

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            idle();
            wr_en = vt[i].we;
            wr_addr = {vt[i].wa1, vt[i].wa0};
            wr_data = {vt[i].wd1, vt[i].wd0};
            sb_set_en = vt[i].sb; sb_set_addr = vt[i].sa;
            rd_addr[0 +: AW] = vt[i].ra0; rd_addr[AW +: AW] = vt[i].ra1;
            #1;
            chk($sformatf("vec%0d rd_data0", i), {32'h0, rd_data[31:0]}, {32'h0, vt[i].d0});
            chk($sformatf("vec%0d rd_data1", i), {32'h0, rd_data[63:32]}, {32'h0, vt[i].d1});
            chk($sformatf("vec%0d rd_busy", i), {62'h0, rd_busy[1:0]}, {62'h0, vt[i].busy});
            chk($sformatf("vec%0d pending_cnt", i), {58'h0, pending_cnt}, {58'h0, vt[i].cnt});
        end
        @(negedge clk);
        idle();

        // No-bypass instance: old value and busy persist until the edge
        nb_wr_en = 2'b01; nb_wr_addr[0 +: AW] = 5'd7; nb_wr_data[0 +: 32] = 32'h1234;
        nb_rd_addr[0 +: AW] = 5'd7;
        #1;
        chk("nobyp r7 before edge", {32'h0, nb_rd_data[31:0]}, 64'h0);
        @(negedge clk);
        nb_wr_en = 2'b00;
        #1;
        chk("nobyp r7 after edge", {32'h0, nb_rd_data[31:0]}, 64'h1234);
        @(negedge clk);
        nb_sb_set_en = 1'b1; nb_sb_set_addr = 5'd9;
        @(negedge clk);
        nb_sb_set_en = 1'b0;
        nb_wr_en = 2'b10; nb_wr_addr[AW +: AW] = 5'd9; nb_wr_data[32 +: 32] = 32'h55;
        nb_rd_addr[AW +: AW] = 5'd9;
        #1;
        chk("nobyp busy r9 during write", {63'h0, nb_rd_busy[1]}, 64'h1);
        chk("nobyp cnt set", {58'h0, nb_pending_cnt}, 64'h1);
        @(negedge clk);
        nb_wr_en = 2'b00;
        #1;
        chk("nobyp busy r9 after write", {63'h0, nb_rd_busy[1]}, 64'h0);
        chk("nobyp cnt cleared", {58'h0, nb_pending_cnt}, 64'h0);
        chk("nobyp r9 data", {32'h0, nb_rd_data[63:32]}, 64'h55);

        // Random traffic against the reference model
        @(negedge clk);
        idle();
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        for (int r = 0; r < 24; r++) mregs[r] = '0;
        mpend = '0;
        for (int c = 0; c < 10000; c++) begin
            logic [31:0] exp_d;
            logic        exp_b;
            int          pc;
            @(negedge clk);
            wr_en = 2'($urandom_range(0, 3));
            for (int w = 0; w < 2; w++) begin
                wr_addr[w*AW +: AW] = 5'($urandom_range(0, 31));
                wr_data[w*32 +: 32] = $urandom;
            end
            sb_set_en = 1'($urandom_range(0, 1));
            sb_set_addr = 5'($urandom_range(0, 31));
            for (int p = 0; p < 4; p++) rd_addr[p*AW +: AW] = 5'($urandom_range(0, 31));
            #1;
            for (int p = 0; p < 4; p++) begin
                int a;
                a = int'(rd_addr[p*AW +: AW]);
                exp_d = '0;
                exp_b = 1'b0;
                if (m_ok(a)) begin
                    exp_d = mregs[a];
                    exp_b = mpend[a];
                    for (int w = 0; w < 2; w++) begin
                        if (wr_en[w] && int'(wr_addr[w*AW +: AW]) == a) begin
                            exp_d = wr_data[w*32 +: 32];
                            exp_b = 1'b0;
                        end
                    end
                end
                chk($sformatf("rand c%0d p%0d data", c, p), {32'h0, rd_data[p*32 +: 32]}, {32'h0, exp_d});
                chk($sformatf("rand c%0d p%0d busy", c, p), {63'h0, rd_busy[p]}, {63'h0, exp_b});
            end
            pc = 0;
            for (int r = 0; r < 24; r++) pc += int'(mpend[r]);
            chk($sformatf("rand c%0d pending_cnt", c), {58'h0, pending_cnt}, 64'(pc));
            for (int w = 0; w < 2; w++) begin
                if (wr_en[w] && m_ok(int'(wr_addr[w*AW +: AW]))) begin
                    mregs[int'(wr_addr[w*AW +: AW])] = wr_data[w*32 +: 32];
                    mpend[int'(wr_addr[w*AW +: AW])] = 1'b0;
                end
            end
            if (sb_set_en && m_ok(int'(sb_set_addr))) mpend[int'(sb_set_addr)] = 1'b1;
        end
        @(negedge clk);
        idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
